// File: rtl/i2c_pad_conditioner.sv
// Pad-side conditioning for the I2C SCL/SDA lines: synchronise, deglitch, START/STOP and stuck-SCL detection.
// Optional statistics counters are built when I2C_PAD_CONDITIONER_STATS_EN is defined.
module i2c_pad_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int STUCK_TIMEOUT = 65535
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
`ifdef I2C_PAD_CONDITIONER_STATS_EN
  input  logic        stats_clr_i,
  output logic [15:0] start_cnt_o,
  output logic [15:0] glitch_cnt_o,
`endif
  output logic        scl_o,
  output logic        sda_o,
  output logic        start_det_o,
  output logic        stop_det_o,
  output logic        bus_busy_o,
  output logic        scl_stuck_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(STUCK_TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_TIMEOUT);

  typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic [1:0]             synced;
  logic [1:0]             filt;
  logic [FW-1:0]          fcnt [2];
  logic                   scl_q;
  logic                   sda_q;
  logic                   start_cond;
  logic                   stop_cond;
  logic [SW-1:0]          stuck_cnt;
  bus_state_t             bus_state;
  bus_state_t             bus_next;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad_i};
    end
  end

  // Index 0 is SCL, index 1 is SDA throughout the filter.
  assign synced = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] != filt[i]) begin
          if (fcnt[i] == FILT_LAST) begin
            filt[i] <= synced[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign scl_o = filt[0];
  assign sda_o = filt[1];

  // A simultaneous SCL change breaks the scl_q/scl_o both-high condition, so it is neither START nor STOP.
  assign start_cond = sda_q & ~sda_o & scl_q & scl_o;
  assign stop_cond  = ~sda_q & sda_o & scl_q & scl_o;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
    end else begin
      scl_q       <= scl_o;
      sda_q       <= sda_o;
      start_det_o <= start_cond;
      stop_det_o  <= stop_cond;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus_state <= BUS_IDLE;
    end else begin
      bus_state <= bus_next;
    end
  end

  always_comb begin
    bus_next = bus_state;
    if (stop_cond) begin
      bus_next = BUS_IDLE;
    end else if (start_cond) begin
      bus_next = BUS_BUSY;
    end
  end

  assign bus_busy_o = (bus_state == BUS_BUSY);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stuck_cnt <= '0;
    end else if (!scl_o) begin
      if (stuck_cnt != STUCK_MAX) begin
        stuck_cnt <= stuck_cnt + 1'b1;
      end
    end else begin
      stuck_cnt <= '0;
    end
  end

  assign scl_stuck_o = (stuck_cnt == STUCK_MAX);

`ifdef I2C_PAD_CONDITIONER_STATS_EN
  logic [1:0]  glitch;
  logic [16:0] glitch_sum;

  // A glitch is a pending flip that was abandoned because the line settled back.
  always_comb begin
    glitch = 2'b00;
    for (int i = 0; i < 2; i++) begin
      glitch[i] = (synced[i] == filt[i]) && (fcnt[i] != '0);
    end
  end

  assign glitch_sum = {1'b0, glitch_cnt_o} + 17'(glitch[0]) + 17'(glitch[1]);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || stats_clr_i) begin
      start_cnt_o  <= '0;
      glitch_cnt_o <= '0;
    end else begin
      if (start_cond && start_cnt_o != 16'hFFFF) begin
        start_cnt_o <= start_cnt_o + 1'b1;
      end
      glitch_cnt_o <= glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Randomised self-checking bench for i2c_pad_conditioner against a history-based reference model.
// Stats checks are included when I2C_PAD_CONDITIONER_STATS_EN is defined.
module tb_i2c_pad_conditioner;

  localparam int S = 2;
  localparam int F = 4;
  localparam int T = 100;
  localparam int HMAX = 16384;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic scl_pad_i = 1'b0;
  logic sda_pad_i = 1'b0;
  logic scl_o, sda_o, start_det_o, stop_det_o, bus_busy_o, scl_stuck_o;
`ifdef I2C_PAD_CONDITIONER_STATS_EN
  logic stats_clr_i = 1'b0;
  logic [15:0] start_cnt_o, glitch_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: pad history per line (value entering the synchroniser at each edge).
  bit ph [2][0:HMAX-1];
  int e;
  bit mFilt [2];
  bit mQ [2];
  bit mStart, mStop, mBusy;
  int lowRun;
  int diffRun [2];
  int mStartCnt, mGlitchCnt;

  i2c_pad_conditioner #(
    .SYNC_STAGES(S),
    .FILTER_LEN(F),
    .STUCK_TIMEOUT(T)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .scl_pad_i(scl_pad_i),
    .sda_pad_i(sda_pad_i),
`ifdef I2C_PAD_CONDITIONER_STATS_EN
    .stats_clr_i(stats_clr_i),
    .start_cnt_o(start_cnt_o),
    .glitch_cnt_o(glitch_cnt_o),
`endif
    .scl_o(scl_o),
    .sda_o(sda_o),
    .start_det_o(start_det_o),
    .stop_det_o(stop_det_o),
    .bus_busy_o(bus_busy_o),
    .scl_stuck_o(scl_stuck_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A line flips when its synchronised level has disagreed with the output for the last F edges.
  task automatic modelStep(input bit rst, input bit scl, input bit sda, input bit clr);
    bit pads [2];
    bit newFilt [2];
    bit synced, flip, st, sp;
    int g;
    pads[0] = scl;
    pads[1] = sda;
    if (rst) begin
      for (int L = 0; L < 2; L++) begin
        for (int j = 0; j < S; j++) ph[L][e-j] = 1'b1;
        mFilt[L] = 1'b1;
        mQ[L] = 1'b1;
        diffRun[L] = 0;
      end
      mStart = 0; mStop = 0; mBusy = 0; lowRun = 0;
      mStartCnt = 0; mGlitchCnt = 0;
    end else begin
      g = 0;
      for (int L = 0; L < 2; L++) begin
        synced = ph[L][e-S];
        flip = 1'b1;
        for (int k = 0; k < F; k++) if (ph[L][e-S-k] == mFilt[L]) flip = 1'b0;
        newFilt[L] = flip ? !mFilt[L] : mFilt[L];
        if (synced == mFilt[L]) begin
          if (diffRun[L] > 0) g++;
          diffRun[L] = 0;
        end else if (flip) begin
          diffRun[L] = 0;
        end else begin
          diffRun[L]++;
        end
      end
      st = mQ[1] && !mFilt[1] && mQ[0] && mFilt[0];
      sp = !mQ[1] && mFilt[1] && mQ[0] && mFilt[0];
      lowRun = mFilt[0] ? 0 : lowRun + 1;
      if (sp) mBusy = 0;
      else if (st) mBusy = 1;
      mStart = st;
      mStop = sp;
      if (clr) begin
        mStartCnt = 0;
        mGlitchCnt = 0;
      end else begin
        mStartCnt = (mStartCnt + int'(st) > 65535) ? 65535 : mStartCnt + int'(st);
        mGlitchCnt = (mGlitchCnt + g > 65535) ? 65535 : mGlitchCnt + g;
      end
      for (int L = 0; L < 2; L++) begin
        mQ[L] = mFilt[L];
        mFilt[L] = newFilt[L];
        ph[L][e] = pads[L];
      end
    end
    e++;
  endtask

  task automatic compareAll();
    checkOutput("scl_o", 16'(scl_o), 16'(mFilt[0]));
    checkOutput("sda_o", 16'(sda_o), 16'(mFilt[1]));
    checkOutput("start_det", 16'(start_det_o), 16'(mStart));
    checkOutput("stop_det", 16'(stop_det_o), 16'(mStop));
    checkOutput("bus_busy", 16'(bus_busy_o), 16'(mBusy));
    checkOutput("scl_stuck", 16'(scl_stuck_o), 16'(lowRun >= T));
`ifdef I2C_PAD_CONDITIONER_STATS_EN
    checkOutput("start_cnt", start_cnt_o, 16'(mStartCnt));
    checkOutput("glitch_cnt", glitch_cnt_o, 16'(mGlitchCnt));
`endif
  endtask

  task automatic applyStimulus(input bit rst, input bit scl, input bit sda, input bit clr);
    wb_rst_i = rst;
    scl_pad_i = scl;
    sda_pad_i = sda;
`ifdef I2C_PAD_CONDITIONER_STATS_EN
    stats_clr_i = clr;
`endif
    @(posedge wb_clk_i);
`ifdef I2C_PAD_CONDITIONER_STATS_EN
    modelStep(rst, scl, sda, clr);
`else
    modelStep(rst, scl, sda, 1'b0);
`endif
    @(negedge wb_clk_i);
    cyc++;
    compareAll();
  endtask

  task automatic hold(input int n, input bit rst, input bit scl, input bit sda);
    for (int i = 0; i < n; i++) applyStimulus(rst, scl, sda, 1'b0);
  endtask

  initial begin
    for (int L = 0; L < 2; L++) for (int i = 0; i < HMAX; i++) ph[L][i] = 1'b1;
    e = 16;
    // Reset with pads low, then release: both lines fall together, no START.
    hold(3, 1, 0, 0);
    hold(10, 0, 0, 0);
    hold(12, 0, 1, 1);
    // Short SDA glitch.
    hold(3, 0, 1, 0);
    hold(10, 0, 1, 1);
    // START, SCL pulse, STOP.
    hold(10, 0, 1, 0);
    hold(8, 0, 0, 0);
    hold(8, 0, 1, 0);
    hold(10, 0, 1, 1);
    // START, data bit, repeated START, then STOP.
    hold(10, 0, 1, 0);
    hold(8, 0, 0, 0);
    hold(8, 0, 0, 1);
    hold(8, 0, 1, 1);
    hold(10, 0, 1, 0);
    hold(8, 0, 0, 0);
    hold(8, 0, 1, 0);
    hold(10, 0, 1, 1);
    // Stuck SCL and release.
    hold(120, 0, 0, 1);
    hold(10, 0, 1, 1);
    // Busy and stuck, then reset mid-transaction.
    hold(10, 0, 1, 0);
    hold(112, 0, 0, 0);
    hold(1, 1, 0, 0);
    hold(10, 0, 1, 1);
    // Randomised segments with occasional resets, clears and long SCL lows.
    for (int seg = 0; seg < 400; seg++) begin
      bit rs, sc, sd;
      int len;
      rs = ($urandom_range(0, 39) == 0);
      sc = 1'($urandom);
      sd = 1'($urandom);
      len = ($urandom_range(0, 29) == 0) ? int'($urandom_range(95, 130)) : int'($urandom_range(1, 9));
      if (rs) len = int'($urandom_range(1, 2));
      if (len > 20) sc = 1'b0;
      for (int i = 0; i < len; i++) applyStimulus(rs, sc, sd, ($urandom_range(0, 29) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_pad_conditioner.md
Name: i2c_pad_conditioner

Overview:
Input conditioning stage between the SCL/SDA pads (io_in[8], io_in[9]) and the I2C master's scl_i/sda_i inputs. It synchronises both lines, rejects glitches shorter than a programmable number of clocks, and detects START/STOP conditions. It also tracks bus-busy state and flags SCL held low beyond a timeout. Its outputs feed the master's receive inputs and the IRQ/status logic in user_project.

Parameters:
SYNC_STAGES, 2, synchroniser flops per line (>=2)
FILTER_LEN, 4, consecutive cycles a synchronised level must differ from the filtered output before the output flips (>=1)
STUCK_TIMEOUT, 65535, consecutive cycles of filtered SCL low before scl_stuck_o asserts (>=1)

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
scl_pad_i  input  1  raw SCL from pad
sda_pad_i  input  1  raw SDA from pad
scl_o  output  1  filtered SCL, to master scl_i
sda_o  output  1  filtered SDA, to master sda_i
start_det_o  output  1  one-cycle pulse on START or repeated START
stop_det_o  output  1  one-cycle pulse on STOP
bus_busy_o  output  1  high between START and STOP
scl_stuck_o  output  1  SCL low for >= STUCK_TIMEOUT cycles

Behaviour:
- One clock (wb_clk_i); reset is synchronous and active-high (wb_rst_i). All state updates on the rising edge.
- Reset values: synchroniser flops = 1, scl_o = 1, sda_o = 1, filter counters = 0, start_det_o = 0, stop_det_o = 0, bus_busy_o = 0, scl_stuck_o = 0, stuck counter = 0.
- A reset asserted mid-transaction returns all state to reset values on the next edge. No START/STOP pulse is generated for the forced return to idle.
- Synchroniser: each pad passes through a SYNC_STAGES-deep flop chain.
- Filter, per line:
  - A counter runs while the synchronised level differs from the filtered output.
  - If the counter equals FILTER_LEN-1 and the levels still differ, the output flips on that edge and the counter clears.
  - If the levels are equal in any cycle, the counter clears.
  - Pad-to-output latency = SYNC_STAGES + FILTER_LEN edges. With the defaults, a pad change held stable appears on scl_o/sda_o at edge 6.
  - Counter width = $clog2(FILTER_LEN+1).
- Edge detection uses registered copies of scl_o/sda_o from the previous cycle (scl_q, sda_q).
  - START: sda_q=1, sda_o=0, scl_q=1, scl_o=1. start_det_o pulses high for exactly the next cycle, one edge after sda_o falls.
  - STOP: sda_q=0, sda_o=1, scl_q=scl_o=1. stop_det_o pulses on the next cycle.
  - SCL and SDA changing in the same cycle is neither START nor STOP.
- bus_busy_o:
  - Set on the cycle start_det_o asserts.
  - Cleared on the cycle stop_det_o asserts.
  - A repeated START keeps it high.
  - If start and stop would be seen in the same cycle (not possible under the rules above), stop wins.
- Stuck detector:
  - The counter increments each cycle scl_o=0 and saturates at STUCK_TIMEOUT.
  - scl_stuck_o = 1 when counter == STUCK_TIMEOUT.
  - When scl_o=1, the counter clears and scl_stuck_o drops on the next edge.
  - Counter width = $clog2(STUCK_TIMEOUT+1).

Optional Feature:
Macro I2C_PAD_CONDITIONER_STATS_EN.
- Defined: adds ports stats_clr_i (input 1), start_cnt_o (output 16), glitch_cnt_o (output 16).
  - start_cnt_o increments on each start_det_o pulse.
  - glitch_cnt_o increments, per line, whenever a filter counter is nonzero and the levels become equal before the flip. SCL and SDA glitches in the same cycle count +2.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - stats_clr_i zeroes both counters on the next edge and wins over a simultaneous increment.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Defaults (SYNC_STAGES=2, FILTER_LEN=4). Pads at 0 during 3 reset cycles -> scl_o=sda_o=1, busy=0 throughout reset. After release with pads held 0, scl_o and sda_o fall at edge 6; no start pulse (simultaneous change).
2. Pads idle high. sda_pad_i low for 3 cycles, then high -> sda_o stays 1, no start_det_o; with STATS_EN, glitch_cnt_o=1.
3. SCL high, SDA pad low for 10 cycles -> sda_o falls at edge 6, start_det_o high only during cycle 7, bus_busy_o=1 from cycle 7. start_cnt_o=1 with STATS_EN.
4. Continue from test 3: SCL low then high, then SDA high while SCL high -> one stop_det_o pulse, bus_busy_o=0. A second START before the STOP (repeated START) keeps busy=1 and gives start_cnt_o=2.
5. STUCK_TIMEOUT=100. SCL pad low for 120 cycles -> scl_stuck_o asserts exactly 100 cycles after scl_o falls and stays high. SCL released -> scl_stuck_o drops 1 edge after scl_o rises.
6. Assert wb_rst_i while bus_busy_o=1 and scl_stuck_o=1 -> next edge: all outputs at reset values, no stop pulse. With STATS_EN, stats_clr_i during an increment gives counters = 0.
